// File: rtl/cnn_ctrl_params.sv
// Shared parameters and types for the CNN scan controllers.
//   - Default field widths and IFM row-buffer count used by cnn_tile_ctrl.
//   - ctrl_state_e: controller phase (idle, frame sync, row sync, data beats).
package cnn_ctrl_params;

  localparam int W_SIZE_DEF       = 9;
  localparam int W_CHANNEL_DEF    = 9;
  localparam int W_FRAME_SIZE_DEF = 20;
  localparam int IFM_BUF_CNT_DEF  = 4;
  localparam int W_IFM_BUF_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VSYNC = 2'd1,
    ST_HSYNC = 2'd2,
    ST_DATA  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/cnn_scan_cnt.sv
// Stepped (row, col, chn) scan counter.
//   clk, rstn      : clock, async active-low reset
//   clr            : synchronous clear to (0,0,0)
//   step           : advance by one beat (chn innermost, then col, then row)
//   stride2        : col/row step is 2 instead of 1
//   width, height  : frame size; channel: input channel tiles
//   row, col, chn  : current position
//   last_chn/col/row : current position is the last along that axis
// The counter wraps to (0,0,0) after the last beat of a frame.
module cnn_scan_cnt #(
  parameter int W_SIZE    = 9,
  parameter int W_CHANNEL = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 step,
  input  logic                 stride2,
  input  logic [W_SIZE-1:0]    width,
  input  logic [W_SIZE-1:0]    height,
  input  logic [W_CHANNEL-1:0] channel,
  output logic [W_SIZE-1:0]    row,
  output logic [W_SIZE-1:0]    col,
  output logic [W_CHANNEL-1:0] chn,
  output logic                 last_chn,
  output logic                 last_col,
  output logic                 last_row
);

  logic [W_SIZE:0]    step_sz;
  logic [W_SIZE:0]    col_nxt;
  logic [W_SIZE:0]    row_nxt;
  logic [W_CHANNEL:0] chn_nxt;

  // One extra bit so col+s / row+s never wraps before the compare.
  assign step_sz  = {{(W_SIZE-1){1'b0}}, stride2, ~stride2};
  assign col_nxt  = {1'b0, col} + step_sz;
  assign row_nxt  = {1'b0, row} + step_sz;
  assign chn_nxt  = {1'b0, chn} + (W_CHANNEL+1)'(1);

  assign last_col = col_nxt >= {1'b0, width};
  assign last_row = row_nxt >= {1'b0, height};
  assign last_chn = chn_nxt >= {1'b0, channel};

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
      chn <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      chn <= '0;
    end else if (step) begin
      if (!last_chn) begin
        chn <= chn_nxt[W_CHANNEL-1:0];
      end else begin
        chn <= '0;
        if (!last_col) begin
          col <= col_nxt[W_SIZE-1:0];
        end else begin
          col <= '0;
          row <= last_row ? '0 : row_nxt[W_SIZE-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/cnn_tile_ctrl.sv
// Scan controller: walks the input frame once per output-channel tile in
// (row, col, input-channel-tile) order and sequences IFM row buffers.
//   clk, rstn            : clock, async active-low reset
//   q_start              : start pulse (IDLE only); q_* config latched on accept
//   q_width/q_height     : frame size; q_channel: input tiles; q_out_tiles: passes
//   q_kernel3, q_stride2 : 3x3 window, stride 2
//   q_ifm_buf_done       : per row-buffer "loaded" level
//   q_filter_buf_done    : filter tile for o_out_tile loaded
//   i_stall              : downstream backpressure, freezes beats
//   o_ctrl_*_run         : phase strobes (data_run = beat)
//   o_row/o_col/o_chn    : current beat position; o_out_tile: current tile
//   o_data_count         : beat index within tile
//   o_filter_req         : pulse on first VSYNC cycle of each tile
//   o_ifm_release        : one-cycle mask of freed row buffers
//   o_end_row/tile/frame : last-beat flags; o_busy: not idle
module cnn_tile_ctrl
  import cnn_ctrl_params::*;
#(
  parameter int W_SIZE       = W_SIZE_DEF,
  parameter int W_CHANNEL    = W_CHANNEL_DEF,
  parameter int W_FRAME_SIZE = W_FRAME_SIZE_DEF,
  parameter int IFM_BUF_CNT  = IFM_BUF_CNT_DEF,
  parameter int W_IFM_BUF    = W_IFM_BUF_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel,
  input  logic [W_CHANNEL-1:0]    q_out_tiles,
  input  logic                    q_kernel3,
  input  logic                    q_stride2,
  input  logic [IFM_BUF_CNT-1:0]  q_ifm_buf_done,
  input  logic                    q_filter_buf_done,
  input  logic                    i_stall,
  output logic                    o_ctrl_vsync_run,
  output logic                    o_ctrl_hsync_run,
  output logic                    o_ctrl_data_run,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_CHANNEL-1:0]    o_out_tile,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_filter_req,
  output logic [IFM_BUF_CNT-1:0]  o_ifm_release,
  output logic                    o_end_row,
  output logic                    o_end_tile,
  output logic                    o_end_frame,
  output logic                    o_busy
);

  ctrl_state_e state, state_nxt;

  logic [W_SIZE-1:0]      cfg_width, cfg_height;
  logic [W_CHANNEL-1:0]   cfg_channel, cfg_out_tiles;
  logic                   cfg_k3, cfg_s2;

  logic                   start_ok, beat, last_tile;
  logic                   last_chn, last_col, last_row;
  logic [W_SIZE:0]        row_p1;
  logic [IFM_BUF_CNT-1:0] req_mask, rel_mask;
  logic                   bufs_ready;

  assign start_ok = q_start && (q_width != '0) && (q_height != '0) &&
                    (q_channel != '0) && (q_out_tiles != '0);

  assign beat        = (state == ST_DATA) && !i_stall;
  assign last_tile   = ({1'b0, o_out_tile} + (W_CHANNEL+1)'(1)) >= {1'b0, cfg_out_tiles};
  assign o_end_row   = beat && last_chn && last_col;
  assign o_end_tile  = o_end_row && last_row;
  assign o_end_frame = o_end_tile && last_tile;

  assign o_ctrl_vsync_run = (state == ST_VSYNC);
  assign o_ctrl_hsync_run = (state == ST_HSYNC);
  assign o_ctrl_data_run  = beat;
  assign o_busy           = (state != ST_IDLE);

  cnn_scan_cnt #(
    .W_SIZE    (W_SIZE),
    .W_CHANNEL (W_CHANNEL)
  ) u_scan (
    .clk      (clk),
    .rstn     (rstn),
    .clr      ((state == ST_IDLE) && start_ok),
    .step     (beat),
    .stride2  (cfg_s2),
    .width    (cfg_width),
    .height   (cfg_height),
    .channel  (cfg_channel),
    .row      (o_row),
    .col      (o_col),
    .chn      (o_chn),
    .last_chn (last_chn),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Rows needed before a row may start: r, plus r+1 for a 3x3 window
  // (r-1 is still held from the previous row).
  assign row_p1 = {1'b0, o_row} + (W_SIZE+1)'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_mask = '0;
    req_mask[o_row[W_IFM_BUF-1:0]] = 1'b1;
    if (cfg_k3 && (row_p1 < {1'b0, cfg_height}))
      req_mask[row_p1[W_IFM_BUF-1:0]] = 1'b1;
  end

  assign bufs_ready = &(q_ifm_buf_done | ~req_mask);

  // Rows freed after row r: mid-tile [max(0,r-k), r+s-k-1]; on the last row
  // of a tile everything still held, i.e. [max(0,r-k), min(h-1,r+k)].
  // At most three rows, all with distinct ids since IFM_BUF_CNT >= 4.
  always_comb begin
    int r_lo, r_hi, cand;
    logic [W_IFM_BUF-1:0] cand_id;
    rel_mask = '0;
    r_lo = int'(o_row) - int'(cfg_k3);
    if (last_row) begin
      r_hi = int'(o_row) + int'(cfg_k3);
      if (r_hi > int'(cfg_height) - 1) r_hi = int'(cfg_height) - 1;
    end else begin
      r_hi = int'(o_row) + (cfg_s2 ? 2 : 1) - int'(cfg_k3) - 1;
    end
    if (r_lo < 0) r_lo = 0;
    for (int i = 0; i < 3; i++) begin
      cand    = r_lo + i;
      cand_id = W_IFM_BUF'(cand);
      if (cand <= r_hi) rel_mask[cand_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_ok)          state_nxt = ST_VSYNC;
      ST_VSYNC: if (q_filter_buf_done) state_nxt = ST_HSYNC;
      ST_HSYNC: if (bufs_ready)        state_nxt = ST_DATA;
      ST_DATA: begin
        if (o_end_frame)     state_nxt = ST_IDLE;
        else if (o_end_tile) state_nxt = ST_VSYNC;
        else if (o_end_row)  state_nxt = ST_HSYNC;
      end
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      cfg_width     <= '0;
      cfg_height    <= '0;
      cfg_channel   <= '0;
      cfg_out_tiles <= '0;
      cfg_k3        <= 1'b0;
      cfg_s2        <= 1'b0;
      o_out_tile    <= '0;
      o_data_count  <= '0;
      o_filter_req  <= 1'b0;
      o_ifm_release <= '0;
    end else begin
      state         <= state_nxt;
      o_filter_req  <= (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
      o_ifm_release <= o_end_row ? rel_mask : '0;
      if ((state == ST_IDLE) && start_ok) begin
        cfg_width     <= q_width;
        cfg_height    <= q_height;
        cfg_channel   <= q_channel;
        cfg_out_tiles <= q_out_tiles;
        cfg_k3        <= q_kernel3;
        cfg_s2        <= q_stride2;
        o_out_tile    <= '0;
        o_data_count  <= '0;
      end else if (o_end_tile) begin
        o_out_tile    <= o_out_tile + W_CHANNEL'(1);
        o_data_count  <= '0;
      end else if (beat) begin
        o_data_count  <= o_data_count + W_FRAME_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_cnn_tile_ctrl.sv
// Self-checking bench for cnn_tile_ctrl: a nested-loop reference model builds
// the expected beat sequence and release masks; random stall, buffer-done
// and filter-done levels exercise the handshakes.
module tb_cnn_tile_ctrl;

  localparam int W_SIZE       = 9;
  localparam int W_CHANNEL    = 9;
  localparam int W_FRAME_SIZE = 20;
  localparam int IFM_BUF_CNT  = 4;
  localparam int W_IFM_BUF    = 2;
  localparam int FRAME_LIMIT  = 20000;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    q_start;
  logic [W_SIZE-1:0]       q_width, q_height;
  logic [W_CHANNEL-1:0]    q_channel, q_out_tiles;
  logic                    q_kernel3, q_stride2;
  logic [IFM_BUF_CNT-1:0]  q_ifm_buf_done;
  logic                    q_filter_buf_done;
  logic                    i_stall;
  logic                    o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
  logic [W_SIZE-1:0]       o_row, o_col;
  logic [W_CHANNEL-1:0]    o_chn, o_out_tile;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic                    o_filter_req;
  logic [IFM_BUF_CNT-1:0]  o_ifm_release;
  logic                    o_end_row, o_end_tile, o_end_frame, o_busy;

  cnn_tile_ctrl #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .W_FRAME_SIZE(W_FRAME_SIZE),
    .IFM_BUF_CNT(IFM_BUF_CNT), .W_IFM_BUF(W_IFM_BUF)
  ) dut (
    .clk(clk), .rstn(rstn), .q_start(q_start),
    .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
    .q_out_tiles(q_out_tiles), .q_kernel3(q_kernel3), .q_stride2(q_stride2),
    .q_ifm_buf_done(q_ifm_buf_done), .q_filter_buf_done(q_filter_buf_done),
    .i_stall(i_stall),
    .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_hsync_run(o_ctrl_hsync_run),
    .o_ctrl_data_run(o_ctrl_data_run),
    .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_out_tile(o_out_tile),
    .o_data_count(o_data_count), .o_filter_req(o_filter_req),
    .o_ifm_release(o_ifm_release),
    .o_end_row(o_end_row), .o_end_tile(o_end_tile), .o_end_frame(o_end_frame),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int row, col, chn, tile, cnt;
    bit er, et, ef;
  } beat_t;

  beat_t      beat_q[$];
  logic [3:0] rel_q[$];

  // active frame configuration (model side)
  int cfg_w, cfg_h, cfg_c, cfg_t;
  bit cfg_k3, cfg_s2, rand_mode;

  // monitor state
  bit prev_end_row, prev_hs, prev_ready, prev_stall_data, start_pending;
  int prev_cnt, beats_seen, burst, freq_cnt;

  // Reference: plain nested loops over the frame, tracking which rows each
  // tile holds in the IFM buffers.
  function automatic void build_model();
    int s, k, cnt, lo;
    bit held[32];
    logic [3:0] mask;
    beat_t b;
    beat_q.delete();
    rel_q.delete();
    s = cfg_s2 ? 2 : 1;
    k = cfg_k3 ? 1 : 0;
    for (int t = 0; t < cfg_t; t++) begin
      foreach (held[i]) held[i] = 0;
      cnt = 0;
      for (int r = 0; r < cfg_h; r += s) begin
        held[r] = 1;
        if (k == 1 && r + 1 < cfg_h) held[r+1] = 1;
        for (int c = 0; c < cfg_w; c += s)
          for (int ch = 0; ch < cfg_c; ch++) begin
            b.row = r; b.col = c; b.chn = ch; b.tile = t; b.cnt = cnt++;
            b.er = (c + s >= cfg_w) && (ch == cfg_c - 1);
            b.et = b.er && (r + s >= cfg_h);
            b.ef = b.et && (t == cfg_t - 1);
            beat_q.push_back(b);
          end
        mask = '0;
        lo = (r - k < 0) ? 0 : r - k;
        if (r + s < cfg_h) begin
          for (int rr = lo; rr <= r + s - k - 1; rr++) begin
            mask[rr % 4] = 1'b1;
            held[rr] = 0;
          end
        end else begin
          for (int rr = lo; rr < 32; rr++)
            if (held[rr]) begin
              mask[rr % 4] = 1'b1;
              held[rr] = 0;
            end
        end
        rel_q.push_back(mask);
      end
    end
  endfunction

  function automatic bit rows_ready(int r, logic [3:0] done);
    bit ok;
    ok = done[r % 4];
    if (cfg_k3 && r + 1 < cfg_h) ok = ok && done[(r + 1) % 4];
    return ok;
  endfunction

  task automatic drive_inputs();
    if (start_pending) begin
      q_start = 1'b1;
      start_pending = 0;
    end else begin
      q_start = 1'b0;
      if (rand_mode) begin
        // config ports may wander once the frame is accepted
        q_width   = W_SIZE'($urandom);
        q_height  = W_SIZE'($urandom);
        q_channel = W_CHANNEL'($urandom);
        q_kernel3 = 1'($urandom);
      end
    end
    if (rand_mode) begin
      i_stall           = (burst > 0) || ($urandom_range(0, 3) == 0);
      q_ifm_buf_done    = 4'($urandom);
      q_filter_buf_done = 1'($urandom);
    end else begin
      i_stall           = (burst > 0);
      q_ifm_buf_done    = '1;
      q_filter_buf_done = 1'b1;
    end
    if (burst > 0) burst--;
  endtask

  // One cycle: drive inputs after the falling edge, then sample/check.
  task automatic step_cycle();
    bit in_data;
    logic [3:0] exp_rel;
    beat_t b;
    @(negedge clk);
    drive_inputs();
    #1;
    in_data = o_busy && !o_ctrl_vsync_run && !o_ctrl_hsync_run;
    if (prev_end_row) begin
      exp_rel = (rel_q.size() > 0) ? rel_q.pop_front() : 4'h0;
      check("release", o_ifm_release, exp_rel);
    end else if (o_ifm_release != '0) begin
      check("release_spurious", o_ifm_release, 0);
    end
    if (prev_hs) check("hsync_gate", in_data, prev_ready);
    if (o_filter_req) begin
      freq_cnt++;
      check("filter_req_in_vsync", o_ctrl_vsync_run, 1);
    end
    if (prev_stall_data) begin
      check("stall_hold_count", o_data_count, prev_cnt);
      check("stall_hold_state", in_data, 1);
    end
    if (o_ctrl_data_run) begin
      if (beat_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        b = beat_q.pop_front();
        check("row", o_row, b.row);
        check("col", o_col, b.col);
        check("chn", o_chn, b.chn);
        check("out_tile", o_out_tile, b.tile);
        check("data_count", o_data_count, b.cnt);
        check("end_row", o_end_row, b.er);
        check("end_tile", o_end_tile, b.et);
        check("end_frame", o_end_frame, b.ef);
      end
      beats_seen++;
      if (beats_seen == 5) burst = 5;
    end else if (o_end_row || o_end_tile || o_end_frame) begin
      check("end_flags_no_beat", {o_end_row, o_end_tile, o_end_frame}, 0);
    end
    prev_end_row    = o_end_row;
    prev_stall_data = in_data && i_stall;
    prev_cnt        = int'(o_data_count);
    prev_hs         = o_ctrl_hsync_run;
    prev_ready      = (beat_q.size() > 0) ? rows_ready(beat_q[0].row, q_ifm_buf_done) : 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int c, input int t,
                           input bit k3, input bit s2, input bit rm);
    int cyc, first_vs, first_hs, first_beat;
    cfg_w = w; cfg_h = h; cfg_c = c; cfg_t = t;
    cfg_k3 = k3; cfg_s2 = s2; rand_mode = rm;
    q_width = W_SIZE'(w); q_height = W_SIZE'(h);
    q_channel = W_CHANNEL'(c); q_out_tiles = W_CHANNEL'(t);
    q_kernel3 = k3; q_stride2 = s2;
    build_model();
    prev_end_row = 0; prev_hs = 0; prev_ready = 0; prev_stall_data = 0;
    beats_seen = 0; burst = 0; freq_cnt = 0;
    start_pending = 1;
    first_vs = -1; first_hs = -1; first_beat = -1;
    cyc = 0;
    do begin
      step_cycle();
      if (first_vs < 0 && o_ctrl_vsync_run) first_vs = cyc;
      if (first_hs < 0 && o_ctrl_hsync_run) first_hs = cyc;
      if (first_beat < 0 && o_ctrl_data_run) first_beat = cyc;
      cyc++;
    end while (cyc < FRAME_LIMIT && (o_busy || beat_q.size() > 0 || cyc == 1));
    check("frame_done_in_budget", (cyc < FRAME_LIMIT), 1);
    check("beats_remaining", beat_q.size(), 0);
    check("releases_remaining", rel_q.size(), 0);
    check("filter_req_count", freq_cnt, t);
    if (!rm) begin
      check("latency_vsync", first_vs, 1);
      check("latency_hsync", first_hs, 2);
      check("latency_beat", first_beat, 3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_strobes"}, {o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run}, 0);
    check({tag, "_pos"}, {o_row, o_col, o_chn, o_out_tile}, 0);
    check({tag, "_count"}, o_data_count, 0);
    check({tag, "_pulses"}, {o_filter_req, o_ifm_release, o_end_row, o_end_tile, o_end_frame}, 0);
  endtask

  initial begin
    rstn = 1'b0; q_start = 1'b0;
    q_width = '0; q_height = '0; q_channel = '0; q_out_tiles = '0;
    q_kernel3 = 1'b0; q_stride2 = 1'b0;
    q_ifm_buf_done = '0; q_filter_buf_done = 1'b0; i_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rstn = 1'b1;

    // directed frames from the test plan
    run_frame(4, 4, 2, 1, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, 1, 1, 1'b1, 1'b0, 1'b0);
    run_frame(4, 4, 1, 1, 1'b1, 1'b0, 1'b1);
    run_frame(6, 6, 1, 1, 1'b0, 1'b1, 1'b0);
    run_frame(2, 2, 1, 3, 1'b0, 1'b0, 1'b0);
    run_frame(5, 3, 2, 2, 1'b1, 1'b1, 1'b1);

    // random configurations
    for (int n = 0; n < 10; n++)
      run_frame($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 3),
                $urandom_range(1, 3), 1'($urandom), 1'($urandom), 1'b1);

    // start with one zero field must be rejected
    for (int z = 0; z < 4; z++) begin
      @(negedge clk);
      q_width = 9'd4; q_height = 9'd4; q_channel = 9'd2; q_out_tiles = 9'd1;
      case (z)
        0: q_width = '0;
        1: q_height = '0;
        2: q_channel = '0;
        default: q_out_tiles = '0;
      endcase
      q_start = 1'b1;
      @(negedge clk) q_start = 1'b0;
      repeat (2) @(negedge clk);
      check("reject_zero_cfg", {o_busy, o_ctrl_vsync_run, o_filter_req}, 0);
    end

    // reset asserted in the middle of DATA
    @(negedge clk);
    q_width = 9'd6; q_height = 9'd6; q_channel = 9'd3; q_out_tiles = 9'd2;
    q_kernel3 = 1'b0; q_stride2 = 1'b0;
    q_ifm_buf_done = '1; q_filter_buf_done = 1'b1; i_stall = 1'b0;
    q_start = 1'b1;
    @(negedge clk) q_start = 1'b0;
    begin
      int waited = 0;
      while (waited < 50 && !(o_ctrl_data_run && o_data_count >= 20'd7)) begin
        @(negedge clk);
        waited++;
      end
      check("mid_reset_reached_data", o_ctrl_data_run, 1);
    end
    rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #1 check_reset_outputs("reset_next_cycle");
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
